// File: rtl/adc_seq_clkgen_if.sv
// adc_seq_clkgen_if: control, ADC-side and TX-side signals of the sequencer.
// master = sequencer, slave = the environment driving it.
interface adc_seq_clkgen_if #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int DIV_W = 8
);
  logic             init;
  logic             continuous;
  logic [DIV_W-1:0] half_period;
  logic [N_CH-1:0]  ch_mask;
  logic             eoc_signal;
  logic             wait_tx;
  logic             start_tx;
  logic             clk_adc;
  logic [CH_W-1:0]  ch_sel;
  logic             busy;
  logic             done;
  logic             timeout_err;

  modport master (
    input  init, continuous, half_period, ch_mask,
    input  eoc_signal, wait_tx,
    output start_tx, clk_adc, ch_sel, busy, done,
    output timeout_err
  );

  modport slave (
    output init, continuous, half_period, ch_mask,
    output eoc_signal, wait_tx,
    input  start_tx, clk_adc, ch_sel, busy, done,
    input  timeout_err
  );
endinterface

// File: rtl/adc_seq_clkgen.sv
// adc_seq_clkgen: multi-channel ADC clock generator and scan sequencer.
// Define ADC_SEQ_TIMEOUT_EN to enable the end-of-conversion watchdog.
module adc_seq_clkgen #(
  parameter int N_CH          = 4,
  parameter int CH_W          = 2,
  parameter int DIV_W         = 8,
  parameter int BITS_PER_CONV = 12,
  parameter int EOC_TIMEOUT   = 1023
) (
  input  logic             clk,
  input  logic             reset,
  adc_seq_clkgen_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, CLK_HI, CLK_LO,
    WAIT_EOC, TX_REQ, NEXT
  } state_t;

  localparam logic [7:0]       BITS = 8'(BITS_PER_CONV);
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

  if ((1 << CH_W) < N_CH || BITS_PER_CONV < 1 ||
      BITS_PER_CONV > 255 || EOC_TIMEOUT < 1) begin : g_bad_cfg
    $error("adc_seq_clkgen: illegal parameters");
  end

  state_t           state;
  logic [N_CH-1:0]  mask_q;
  logic             cont_q;
  logic [DIV_W-1:0] hp_q;
  logic [DIV_W-1:0] div_q;
  logic [7:0]       bit_q;
  logic [CH_W-1:0]  ch_q;
  logic             clk_q;
  logic             stx_q;
  logic             busy_q;
  logic             done_q;
  logic [CH_W-1:0]  nxt_ch;
  logic             nxt_hit;

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(EOC_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(EOC_TIMEOUT - 1);
  logic [TO_W-1:0] to_q;
  logic            terr_q;
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  function automatic logic [CH_W-1:0] lowest(
    input logic [N_CH-1:0] m
  );
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i]) r = CH_W'(i);
    return r;
  endfunction

  always_comb begin
    nxt_hit = 1'b0;
    nxt_ch  = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (mask_q[i] && i > int'(ch_q)) begin
        nxt_hit = 1'b1;
        nxt_ch  = CH_W'(i);
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mask_q <= '0;
      cont_q <= 1'b0;
      hp_q   <= '0;
      div_q  <= '0;
      bit_q  <= '0;
      ch_q   <= '0;
      clk_q  <= 1'b0;
      stx_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
      to_q   <= '0;
      terr_q <= 1'b0;
`endif
    end else begin
      stx_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.init && |bus.ch_mask) begin
          mask_q <= bus.ch_mask;
          cont_q <= bus.continuous;
          hp_q   <= (bus.half_period == '0) ?
                    ONE : bus.half_period;
          ch_q   <= lowest(bus.ch_mask);
          busy_q <= 1'b1;
          state  <= SETUP;
`ifdef ADC_SEQ_TIMEOUT_EN
          terr_q <= 1'b0;
`endif
        end
        SETUP: begin
          bit_q <= '0;
          div_q <= hp_q - ONE;
          clk_q <= 1'b1;
          state <= CLK_HI;
        end
        CLK_HI: begin
          if (bus.eoc_signal) begin
            clk_q <= 1'b0;
            state <= TX_REQ;
          end else if (div_q == '0) begin
            clk_q <= 1'b0;
            div_q <= hp_q - ONE;
            state <= CLK_LO;
          end else begin
            div_q <= div_q - ONE;
          end
        end
        CLK_LO: begin
          if (bus.eoc_signal) begin
            state <= TX_REQ;
          end else if (div_q == '0) begin
            bit_q <= bit_q + 8'd1;
            if (bit_q + 8'd1 == BITS) begin
              state <= WAIT_EOC;
`ifdef ADC_SEQ_TIMEOUT_EN
              to_q  <= '0;
`endif
            end else begin
              clk_q <= 1'b1;
              div_q <= hp_q - ONE;
              state <= CLK_HI;
            end
          end else begin
            div_q <= div_q - ONE;
          end
        end
        WAIT_EOC: begin
          if (bus.eoc_signal) begin
            state <= TX_REQ;
`ifdef ADC_SEQ_TIMEOUT_EN
          end else if (to_q == TO_LAST) begin
            terr_q <= 1'b1;
            state  <= NEXT;
          end else begin
            to_q <= to_q + 1'b1;
`endif
          end
        end
        TX_REQ: if (!bus.wait_tx) begin
          stx_q <= 1'b1;
          state <= NEXT;
        end
        NEXT: begin
          if (nxt_hit) begin
            ch_q  <= nxt_ch;
            state <= SETUP;
          end else begin
            done_q <= 1'b1;
            if (cont_q) begin
              ch_q  <= lowest(mask_q);
              state <= SETUP;
            end else begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_tx = stx_q;
  assign bus.clk_adc  = clk_q;
  assign bus.ch_sel   = ch_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_adc_seq_clkgen.sv
// tb_adc_seq_clkgen: trace-model bench for adc_seq_clkgen.
// Expected outputs come from a per-cycle schedule built from the timing rules.
module tb_adc_seq_clkgen;
  localparam int TO   = 16;
  localparam int BITS = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adc_seq_clkgen_if bus ();

  adc_seq_clkgen #(
    .N_CH(4), .CH_W(2), .DIV_W(8),
    .BITS_PER_CONV(BITS), .EOC_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic       clk_adc;
    logic [1:0] ch;
    logic       busy;
    logic       stx;
    logic       done;
    logic       terr;
  } out_t;

  typedef struct packed {
    logic       init;
    logic       eoc;
    logic       wt;
    logic       rst;
    logic [3:0] mask;
    logic [7:0] hp;
    logic       cont;
  } in_t;

  out_t exp_q[$];
  in_t  in_q[$];

  logic [3:0] cfg_mask;
  logic [7:0] cfg_hp;
  logic       cfg_cont;
  bit p_init, p_eoc, p_wait, p_rst, p_noise, p_done;
  int m_ch;
  bit m_terr;

  int checks = 0;
  int passed = 0;
  int nprint = 0;
  int o_rise, o_stx, o_done, o_hi, o_terr;
  int o_stx_ch[$];

  function automatic void emit(bit c, int ch, bit b, bit s);
    out_t e;
    in_t  i;
    e.clk_adc = c;
    e.ch      = 2'(ch);
    e.busy    = b;
    e.stx     = s;
    e.done    = p_done;
    e.terr    = m_terr;
    i.init = p_init | p_noise;
    i.eoc  = p_eoc;
    i.wt   = p_wait;
    i.rst  = p_rst;
    i.mask = p_noise ? ~cfg_mask : cfg_mask;
    i.hp   = p_noise ? cfg_hp + 8'd3 : cfg_hp;
    i.cont = p_noise ? ~cfg_cont : cfg_cont;
    {p_init, p_eoc, p_wait, p_rst, p_noise, p_done} = '0;
    exp_q.push_back(e);
    in_q.push_back(i);
  endfunction

  function automatic void do_reset();
    p_done = 1'b0;
    m_ch   = 0;
    m_terr = 1'b0;
    p_rst  = 1'b1;
    emit(0, 0, 0, 0);
  endfunction

  function automatic void idle(int n);
    repeat (n) emit(0, m_ch, 0, 0);
  endfunction

  function automatic void start();
    m_terr = 1'b0;
    p_init = 1'b1;
  endfunction

  // early>0: EOC sampled in the first high cycle after that many bits
  // eoc_wait<0: EOC never comes, the watchdog ends the conversion
  function automatic void conv(int ch, int hp, int early,
                               int eoc_wait, int txw, bit last);
    int nb;
    m_ch = ch;
    emit(0, ch, 1, 0);
    nb = (early > 0) ? early : BITS;
    for (int b = 0; b < nb; b++) begin
      repeat (hp) emit(1, ch, 1, 0);
      repeat (hp) emit(0, ch, 1, 0);
    end
    if (early > 0) begin
      emit(1, ch, 1, 0);
      p_eoc = 1'b1;
    end else if (eoc_wait < 0) begin
      repeat (TO) emit(0, ch, 1, 0);
      m_terr = 1'b1;
      emit(0, ch, 1, 0);
      if (last) p_done = 1'b1;
      return;
    end else begin
      repeat (eoc_wait + 1) emit(0, ch, 1, 0);
      p_eoc = 1'b1;
    end
    emit(0, ch, 1, 0);
    repeat (txw) begin
      p_wait = 1'b1;
      emit(0, ch, 1, 0);
    end
    emit(0, ch, 1, 1);
    if (last) p_done = 1'b1;
  endfunction

  function automatic void scan(logic [3:0] m, int early,
                               int eoc_wait, int txw);
    int chs[$];
    int hp;
    hp = (cfg_hp == 0) ? 1 : int'(cfg_hp);
    for (int i = 0; i < 4; i++)
      if (m[i]) chs.push_back(i);
    foreach (chs[k])
      conv(chs[k], hp, early, eoc_wait, txw,
           k == chs.size() - 1);
  endfunction

  function automatic int model_rises(int from);
    int n = 0;
    for (int i = from; i < exp_q.size(); i++)
      if (exp_q[i].clk_adc &&
          (i == 0 || !exp_q[i-1].clk_adc)) n++;
    return n;
  endfunction

  function automatic int model_stx(int from, int nth);
    int n = 0;
    for (int i = from; i < exp_q.size(); i++)
      if (exp_q[i].stx) begin
        if (n == nth) return i - from;
        n++;
      end
    return -1;
  endfunction

  task automatic check(string name, int got, int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d",
                  name, got, want);
  endtask

  task automatic run_trace();
    out_t g;
    logic prev;
    {o_rise, o_stx, o_done, o_hi, o_terr} = '0;
    o_stx_ch.delete();
    prev = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      reset           = in_q[i].rst;
      bus.init        = in_q[i].init;
      bus.eoc_signal  = in_q[i].eoc;
      bus.wait_tx     = in_q[i].wt;
      bus.ch_mask     = in_q[i].mask;
      bus.half_period = in_q[i].hp;
      bus.continuous  = in_q[i].cont;
      @(posedge clk);
      @(negedge clk);
      g.clk_adc = bus.clk_adc;
      g.ch      = bus.ch_sel;
      g.busy    = bus.busy;
      g.stx     = bus.start_tx;
      g.done    = bus.done;
      g.terr    = bus.timeout_err;
      checks++;
      if (g === exp_q[i]) passed++;
      else if (nprint < 40) begin
        nprint++;
        $display("FAIL trace[%0d] got %b expected %b %s",
                 i, g, exp_q[i], "(clk,ch,busy,stx,done,terr)");
      end
      if (g.clk_adc === 1'b1 && prev !== 1'b1) o_rise++;
      if (g.clk_adc === 1'b1) o_hi++;
      if (g.stx === 1'b1) begin
        o_stx++;
        o_stx_ch.push_back(int'(g.ch));
      end
      if (g.done === 1'b1) o_done++;
      if (g.terr === 1'b1) o_terr++;
      prev = g.clk_adc;
    end
    exp_q.delete();
    in_q.delete();
  endtask

  initial begin
    int base;
    {p_init, p_eoc, p_wait, p_rst, p_noise, p_done} = '0;
    m_ch = 0;
    m_terr = 1'b0;

    // single channel, hp=2
    cfg_mask = 4'b0001; cfg_hp = 8'd2; cfg_cont = 1'b0;
    do_reset();
    idle(2);
    start();
    base = exp_q.size();
    scan(cfg_mask, 0, 0, 0);
    idle(3);
    check("t1_model_stx_at", model_stx(base, 0), 51);
    check("t1_model_rises", model_rises(base), 12);
    run_trace();
    check("t1_rises", o_rise, 12);
    check("t1_hi_cycles", o_hi, 24);
    check("t1_stx", o_stx, 1);
    check("t1_done", o_done, 1);

    // two-channel scan, hp=0 acts as 1
    cfg_mask = 4'b1010; cfg_hp = 8'd0;
    start();
    base = exp_q.size();
    scan(cfg_mask, 0, 0, 0);
    idle(3);
    check("t2_model_stx0", model_stx(base, 0), 27);
    check("t2_model_stx1", model_stx(base, 1), 55);
    run_trace();
    check("t2_stx", o_stx, 2);
    check("t2_ch_first", o_stx_ch.size() > 0 ? o_stx_ch[0] : -1, 1);
    check("t2_ch_second", o_stx_ch.size() > 1 ? o_stx_ch[1] : -1, 3);
    check("t2_hi_cycles", o_hi, 24);
    check("t2_done", o_done, 1);

    // TX backpressure for 20 cycles
    cfg_mask = 4'b0100; cfg_hp = 8'd1;
    start();
    base = exp_q.size();
    scan(cfg_mask, 0, 0, 20);
    idle(2);
    check("t3_model_stx_at", model_stx(base, 0), 47);
    run_trace();
    check("t3_stx", o_stx, 1);
    check("t3_ch", o_stx_ch.size() > 0 ? o_stx_ch[0] : -1, 2);

    // continuous, early EOC, ignored init, reset in CLK_HI
    cfg_mask = 4'b0101; cfg_hp = 8'd1; cfg_cont = 1'b1;
    start();
    base = exp_q.size();
    scan(cfg_mask, 5, 0, 0);
    p_noise = 1'b1;
    scan(cfg_mask, 5, 0, 0);
    m_ch = 0;
    emit(0, 0, 1, 0);
    emit(1, 0, 1, 0);
    do_reset();
    idle(2);
    cfg_mask = 4'b0000; cfg_cont = 1'b0;
    p_init = 1'b1;
    idle(4);
    check("t4_model_stx3", model_stx(base, 3), 55);
    run_trace();
    check("t4_stx", o_stx, 4);
    check("t4_done", o_done, 2);
    check("t4_rises", o_rise, 25);
    check("t4_wrap_ch", o_stx_ch.size() > 2 ? o_stx_ch[2] : -1, 0);
    check("t4_busy_after_mask0", int'(bus.busy), 0);

`ifdef ADC_SEQ_TIMEOUT_EN
    // EOC never arrives on either channel
    cfg_mask = 4'b0011; cfg_hp = 8'd1;
    start();
    scan(cfg_mask, 0, -1, 0);
    idle(3);
    cfg_mask = 4'b0001;
    start();
    scan(cfg_mask, 0, 2, 0);
    idle(2);
    run_trace();
    check("t5_stx", o_stx, 1);
    check("t5_terr_cycles", o_terr, 46);
    check("t5_terr_cleared", int'(bus.timeout_err), 0);
`else
    // long EOC wait never flags a timeout
    cfg_mask = 4'b0011; cfg_hp = 8'd1;
    start();
    scan(cfg_mask, 0, 20, 0);
    idle(2);
    run_trace();
    check("t5_stx", o_stx, 2);
    check("t5_terr_cycles", o_terr, 0);
    check("t5_done", o_done, 1);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/adc_seq_clkgen.md
# adc_seq_clkgen

Parametrised successor to the single-channel ADC clock generator. Drives a serial ADC clock (`clk_adc`) at a programmable rate and counts a fixed number of clock bits per conversion. Sequences over a channel mask, waits for end-of-conversion, and hands each result to the UART transmitter with a one-cycle `start_tx` pulse gated by `wait_tx`. Sits between the ADC front end and the TX block in the acquisition path.

## Interface
Parameters:
- `N_CH`, 4: number of ADC input channels.
- `CH_W`, 2: width of `ch_sel`; must satisfy 2^CH_W >= N_CH.
- `DIV_W`, 8: width of the half-period divider.
- `BITS_PER_CONV`, 12: `clk_adc` periods per conversion; range 1..255.
- `EOC_TIMEOUT`, 1023: maximum cycles spent in WAIT_EOC (only with the timeout feature).

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `init`  in  1  start request, sampled in IDLE only.
- `continuous`  in  1  latched at `init`; 1 restarts the scan after the last channel.
- `half_period`  in  DIV_W  `clk_adc` half-period in `clk` cycles, latched at `init`; 0 is treated as 1.
- `ch_mask`  in  N_CH  enabled channels, latched at `init`.
- `eoc_signal`  in  1  ADC end-of-conversion, level-sampled.
- `wait_tx`  in  1  transmitter busy; `start_tx` is never issued while it is high.
- `start_tx`  out  1  one-cycle pulse requesting transmission of the current channel result.
- `clk_adc`  out  1  registered ADC clock.
- `ch_sel`  out  CH_W  channel currently being converted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last enabled channel of a scan is handed off.
- `timeout_err`  out  1  sticky flag; cleared by `reset` or by an accepted `init`.

## Operation
- Reset value of every output and of the state is 0. The state resets to IDLE.
- States: IDLE, SETUP, CLK_HI, CLK_LO, WAIT_EOC, TX_REQ, NEXT.
- IDLE:
  - If `init`=1 and `ch_mask`!=0: latch the configuration, set `ch_sel` to the lowest set bit, clear `timeout_err`, and go to SETUP.
  - If `init`=1 and `ch_mask`=0: ignore it and stay in IDLE.
- SETUP: lasts one cycle (mux settle). Clear the bit counter, load the divider, and go to CLK_HI.
- CLK_HI: `clk_adc`=1 for `hp` cycles, where `hp` = max(`half_period`,1). Then go to CLK_LO.
- CLK_LO: `clk_adc`=0 for `hp` cycles. At the end, increment the bit counter.
  - If the counter equals BITS_PER_CONV, go to WAIT_EOC.
  - Otherwise go to CLK_HI.
- `eoc_signal`=1 sampled in CLK_HI or CLK_LO ends the conversion early. The next state is TX_REQ and `clk_adc` goes 0.
- WAIT_EOC: `clk_adc`=0. On `eoc_signal`=1, go to TX_REQ.
- TX_REQ: hold while `wait_tx`=1. In the first cycle with `wait_tx`=0, assert `start_tx` for that cycle and go to NEXT.
- NEXT: lasts one cycle. Search the latched mask for the next set bit above `ch_sel`.
  - If one is found: update `ch_sel` and go to SETUP.
  - If none is found: pulse `done`. Then, if `continuous`=1, set `ch_sel` to the lowest set bit and go to SETUP; otherwise go to IDLE.
- `init` outside IDLE is ignored. Changes to the configuration inputs while busy have no effect.
- `reset` in any state returns all state and outputs to their reset values on the next edge. Any conversion in flight is abandoned.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `init` high at edge 0 gives: `busy`=1 after edge 0, SETUP during cycle 1, `clk_adc` rises after edge 1.
- One conversion's clocking lasts 2·hp·BITS_PER_CONV cycles.
- The first WAIT_EOC cycle follows the last CLK_LO cycle.
- Minimum per-channel overhead outside clocking: SETUP + TX_REQ + NEXT = 3 cycles, plus the EOC wait.
- `start_tx` is exactly 1 cycle wide and never coincides with `wait_tx`=1 in the same cycle.
- `done` coincides with NEXT for the last channel, one cycle after its `start_tx`.
- A bit-counter wrap is impossible: the counter stops at BITS_PER_CONV.

## Configuration
- `ADC_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT_EOC.
  - If EOC_TIMEOUT cycles elapse without `eoc_signal`, set `timeout_err`, skip TX_REQ (no `start_tx`), and go to NEXT.
  - `eoc_signal` arriving in the same cycle the timeout expires counts as EOC and takes priority.
- `ADC_SEQ_TIMEOUT_EN` undefined: WAIT_EOC waits indefinitely, and `timeout_err` is tied to 0.

## Test plan
- Single channel: `half_period`=2, BITS_PER_CONV=12, `ch_mask`=4'b0001, `continuous`=0, `eoc_signal` asserted at WAIT_EOC entry, `wait_tx`=0 -> exactly 12 `clk_adc` pulses, each 2 high / 2 low; one `start_tx`; one `done`; `busy` falls; `ch_sel`=0 throughout.
- Scan: `ch_mask`=4'b1010 -> `ch_sel` is 1 then 3; two `start_tx` pulses; `done` one cycle after the second; `half_period`=0 behaves as 1 (1-high/1-low clock).
- TX backpressure: `wait_tx` held high for 20 cycles in TX_REQ -> no `start_tx` until the first cycle with `wait_tx`=0, then exactly one pulse.
- Continuous mode with early EOC: `continuous`=1, `eoc_signal` pulsed after bit 5 -> clocking stops with `clk_adc`=0; the scan wraps to the lowest channel after `done`; `init` during the run is ignored.
- Timeout (macro defined, EOC_TIMEOUT=16): `eoc_signal` never asserted -> `timeout_err`=1 after 16 WAIT_EOC cycles, no `start_tx`, scan proceeds; the next `init` clears `timeout_err`.
- Reset mid-conversion in CLK_HI: all outputs are 0 on the next edge; `ch_mask`=0 with `init` keeps `busy`=0.
